// File: rtl/rr_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb_pkg
// Description : Shared constants and types for the round-robin arbiter slice.
// Revision    : 1.0
// ============================================================================
package rr_arb_pkg;

    localparam int NUM_CLIENTS = 4;
    localparam int CLIENT_ID_W = 2;
    localparam int IDLE_CNT_W  = 8;

    typedef logic [CLIENT_ID_W-1:0] client_id_t;
    typedef logic [IDLE_CNT_W-1:0]  idle_cnt_t;

    function automatic idle_cnt_t idle_cnt_sat_inc(input idle_cnt_t v);
        return (v == {IDLE_CNT_W{1'b1}}) ? v : idle_cnt_t'(v + 1'b1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_client_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rr_client_fifo
// Description : Synchronous FIFO with occupancy count; push/pop pre-qualified.
// Revision    : 1.0
// ============================================================================
module rr_client_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [DATA_W-1:0]        wdata_i,
    output logic [DATA_W-1:0]        rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;

    // Storage carries no reset: contents are meaningless until counted in.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/rr_arb_client.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb_client
// Description : Requester agent: buffers upstream words, requests the arbiter
//               with lookahead, and emits one word per granted cycle.
// Revision    : 1.0
// ============================================================================
module rr_arb_client
    import rr_arb_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4,
    parameter int CLIENT_ID = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  in_ready,
    output logic                  req,
    input  logic                  gnt,
    output logic                  bus_valid,
    output logic [DATA_W-1:0]     bus_data,
    output client_id_t            bus_id,
    output idle_cnt_t             idle_gnt_cnt
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_d;
    logic [DATA_W-1:0] head;

    logic              bus_valid_q;
    logic              bus_valid_d;
    logic [DATA_W-1:0] bus_data_q;
    logic [DATA_W-1:0] bus_data_d;
    idle_cnt_t         idle_cnt_q;
    idle_cnt_t         idle_cnt_d;

    rr_client_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (in_data),
        .rdata_o (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    // No pass-through when full; pop only against the registered count.
    assign in_ready = ~full;
    assign push     = in_valid & in_ready;
    assign pop      = gnt & ~empty;

    // Lookahead lets req drop in the cycle the last word leaves.
    assign count_d = count + CNT_W'(push) - CNT_W'(pop);
    assign req     = (count_d != '0);

    always_comb begin
        bus_valid_d = pop;
        bus_data_d  = pop ? head : bus_data_q;
        idle_cnt_d  = (gnt & empty) ? idle_cnt_sat_inc(idle_cnt_q) : idle_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_valid_q <= 1'b0;
            bus_data_q  <= '0;
            idle_cnt_q  <= '0;
        end else begin
            bus_valid_q <= bus_valid_d;
            bus_data_q  <= bus_data_d;
            idle_cnt_q  <= idle_cnt_d;
        end
    end

    assign bus_valid    = bus_valid_q;
    assign bus_data     = bus_data_q;
    assign idle_gnt_cnt = idle_cnt_q;
    assign bus_id       = client_id_t'(CLIENT_ID);

endmodule
`default_nettype wire

// File: tb/tb_rr_arb_client.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_arb_client
// Description : Self-checking bench with a queue-based reference model.
// Revision    : 1.0
// ============================================================================
module tb_rr_arb_client;

    localparam int DATA_W    = 8;
    localparam int DEPTH     = 4;
    localparam int CLIENT_ID = 2;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data  = '0;
    logic              gnt      = 1'b0;
    logic              in_ready;
    logic              req;
    logic              bus_valid;
    logic [DATA_W-1:0] bus_data;
    logic [1:0]        bus_id;
    logic [7:0]        idle_gnt_cnt;

    rr_arb_client #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .CLIENT_ID (CLIENT_ID)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .req          (req),
        .gnt          (gnt),
        .bus_valid    (bus_valid),
        .bus_data     (bus_data),
        .bus_id       (bus_id),
        .idle_gnt_cnt (idle_gnt_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: the FIFO is a plain queue, outputs are plain variables.
    logic [DATA_W-1:0] m_q[$];
    logic              m_bv;
    logic [DATA_W-1:0] m_bd;
    int                m_idle;
    bit                pend;
    bit                p_push, p_pop, p_stale;
    logic [DATA_W-1:0] p_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_bv   = 1'b0;
        m_bd   = '0;
        m_idle = 0;
        pend   = 1'b0;
    endtask

    // One clock cycle: commit the model at the edge, drive inputs at negedge,
    // then compare every DUT output against the model.
    task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic g);
        bit ready_e, push_e, pop_e, req_e;
        @(posedge clk);
        if (pend) begin
            if (p_pop) begin
                m_bd = m_q.pop_front();
                m_bv = 1'b1;
            end else begin
                m_bv = 1'b0;
            end
            if (p_stale && m_idle < 255) m_idle++;
            if (p_push) m_q.push_back(p_data);
            pend = 1'b0;
        end
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        gnt      = g;
        #1;
        ready_e = (m_q.size() != DEPTH);
        push_e  = v && ready_e;
        pop_e   = g && (m_q.size() != 0);
        req_e   = (m_q.size() + int'(push_e) - int'(pop_e)) != 0;
        check("in_ready", 32'(in_ready), 32'(ready_e));
        check("req", 32'(req), 32'(req_e));
        check("bus_valid", 32'(bus_valid), 32'(m_bv));
        check("bus_data", 32'(bus_data), 32'(m_bd));
        check("idle_gnt_cnt", 32'(idle_gnt_cnt), 32'(m_idle));
        check("bus_id", 32'(bus_id), 32'(CLIENT_ID));
        p_push  = push_e;
        p_pop   = pop_e;
        p_stale = g && (m_q.size() == 0);
        p_data  = d;
        pend    = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_req", 32'(req), 32'd0);
        check("rst_bus_valid", 32'(bus_valid), 32'd0);
        check("rst_bus_data", 32'(bus_data), 32'd0);
        check("rst_idle", 32'(idle_gnt_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single word through: req in push cycle, bus word one cycle after gnt.
        step(1'b1, 8'hA1, 1'b0);
        check("a1_req_push", 32'(req), 32'd1);
        step(1'b0, 8'h00, 1'b1);
        check("a1_req_gnt", 32'(req), 32'd0);
        step(1'b0, 8'h00, 1'b0);
        check("a1_bus_valid", 32'(bus_valid), 32'd1);
        check("a1_bus_data", 32'(bus_data), 32'hA1);

        // Fill to DEPTH, refuse a 5th, drain in order across pointer wrap.
        for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0);
        step(1'b1, 8'h05, 1'b0);
        check("full_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00, 1'b1);
            if (i > 0) check("drain_data", 32'(bus_data), 32'(i));
        end
        step(1'b0, 8'h00, 1'b0);
        check("drain_last_data", 32'(bus_data), 32'h04);
        check("drain_last_valid", 32'(bus_valid), 32'd1);

        // Stale grant after the only word left, then saturation.
        step(1'b1, 8'h55, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        check("stale_bus_valid", 32'(bus_valid), 32'd0);
        check("stale_idle1", 32'(idle_gnt_cnt), 32'd1);
        repeat (300) step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        check("stale_idle_sat", 32'(idle_gnt_cnt), 32'd255);

        // Asynchronous reset with 3 words queued and gnt high.
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
        step(1'b0, 8'h00, 1'b1);
        rst_n = 1'b0;
        #1;
        check("arst_bus_valid", 32'(bus_valid), 32'd0);
        check("arst_req", 32'(req), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_idle", 32'(idle_gnt_cnt), 32'd0);
        check("arst_bus_data", 32'(bus_data), 32'd0);
        model_reset();
        in_valid = 1'b0;
        gnt      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            step(1'b0, 8'h00, 1'b0);
            check("post_rst_valid", 32'(bus_valid), 32'd0);
        end

        // Push into empty FIFO in the same cycle as gnt: no pop, stale count.
        step(1'b1, 8'h77, 1'b1);
        check("pg_req", 32'(req), 32'd1);
        step(1'b0, 8'h00, 1'b0);
        check("pg_bus_valid", 32'(bus_valid), 32'd0);
        check("pg_idle", 32'(idle_gnt_cnt), 32'd1);
        check("pg_req_hold", 32'(req), 32'd1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        check("pg_bus_data", 32'(bus_data), 32'h77);
        check("pg_bus_valid2", 32'(bus_valid), 32'd1);

        // Randomized traffic with phases of differing fill pressure.
        for (int ph = 0; ph < 6; ph++) begin
            int pv, pg;
            pv = 20 + 15 * ph;
            pg = 90 - 15 * ph;
            for (int n = 0; n < 400; n++) begin
                step(($urandom_range(0, 99) < pv) ? 1'b1 : 1'b0,
                     8'($urandom),
                     ($urandom_range(0, 99) < pg) ? 1'b1 : 1'b0);
            end
        end
        step(1'b0, 8'h00, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rr_arb_client.md
# rr_arb_client

Requester-side agent for the 4-way fixed-time-slice round-robin arbiter. It buffers words from an upstream valid/ready source in a small FIFO and drives its `req` line into one arbiter `REQ` bit. In each cycle its `gnt` line (one arbiter `GNT` bit) is high, it pops one word onto the shared bus. One instance sits per client, between a producer and the arbitrated shared bus.

## Interface

- `DATA_W`, default 8: width of data words.
- `DEPTH`, default 4: FIFO depth. Must be a power of two, ≥2.
- `CLIENT_ID`, default 0: arbiter port index (0..3). Driven on `bus_id`.
- `clk`, input, 1: clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `in_valid`, input, 1: upstream word valid.
- `in_data`, input, `DATA_W`: upstream word.
- `in_ready`, output, 1: FIFO can accept a word.
- `req`, output, 1: request to the arbiter; connects to `REQ[CLIENT_ID]`.
- `gnt`, input, 1: grant from the arbiter; connects to `GNT[CLIENT_ID]`.
- `bus_valid`, output, 1: registered; shared-bus word valid this cycle.
- `bus_data`, output, `DATA_W`: registered shared-bus word.
- `bus_id`, output, 2: constant `CLIENT_ID`.
- `idle_gnt_cnt`, output, 8: saturating count of grants received while the FIFO was empty.

## Operation

- FIFO uses read and write pointers of `$clog2(DEPTH)` bits, which wrap naturally, plus an occupancy `count` of `$clog2(DEPTH)+1` bits.
- `push = in_valid & in_ready`, with `in_ready = (count != DEPTH)`.
  - No pass-through when full: a simultaneous pop while full does not raise `in_ready` in that cycle.
- `pop = gnt & (count != 0)`.
- `count_next = count + push - pop`.
- `req = (count_next != 0)`, combinational.
  - The arbiter computes its next state from `REQ` combinationally but drives `GNT` from a register, so there is no combinational loop.
  - Lookahead purpose: `req` drops in the same cycle the last word is popped, so the arbiter does not schedule a wasted slot.
- On pop: `bus_valid <= 1` and `bus_data <=` FIFO head. Otherwise `bus_valid <= 0` and `bus_data` holds its last value.
- Stale grant: if `gnt` arrives while `count == 0`, the grant reflects a request made in an earlier cycle.
  - No pop, `bus_valid <= 0`.
  - `idle_gnt_cnt` increments, saturating at 255.
- Push into an empty FIFO in the same cycle as `gnt`: no pop, because the pop decision uses the registered `count`. The word waits for the next grant; `req` is high through `count_next`.
- Push and pop in the same cycle with `0 < count < DEPTH`: both occur and `count` is unchanged.
- `bus_id` is tied to `CLIENT_ID[1:0]`.

## Timing

- Reset values:
  - `count`, pointers: 0.
  - `in_ready`: 1.
  - `req`: 0.
  - `bus_valid`: 0.
  - `bus_data`: 0.
  - `idle_gnt_cnt`: 0.
- Reset asserted mid-operation: FIFO contents are discarded and all outputs return to their reset values immediately (asynchronous reset).
- Latency from push to `req` high: 0 cycles (combinational via `count_next`).
- Latency from `req` high to `gnt`, arbiter-determined, for a sole requester:
  - `req` high in cycle N.
  - Arbiter state updates at the edge ending N.
  - `gnt` high in cycle N+1.
- Latency from `gnt`-with-data to `bus_valid`: 1 cycle.
- Throughput: one word per granted cycle. A sole requester with continuous data receives `gnt` every cycle and achieves back-to-back `bus_valid`.
- After `req` falls, at most one further `gnt` can arrive. It is handled as a stale grant.

## Structure

- Shared package `rr_arb_pkg`:
  - `NUM_CLIENTS = 4`.
  - `CLIENT_ID_W = 2`.
  - `IDLE_CNT_W = 8`.
  - Typedef `client_id_t`.
- One natural sub-module: `rr_client_fifo`, the synchronous FIFO with count, `full`/`empty`, and push/pop.
- The top level adds the request lookahead, the bus output register, and the stale-grant counter.

## Test plan

- Reset, then push 0xA1 with `gnt = 0` → `req = 1` in the push cycle, `count = 1`, `bus_valid = 0`. Assert `gnt` one cycle → next cycle `bus_valid = 1`, `bus_data = 0xA1`, `req = 0`.
- Push 0x01..0x04 (DEPTH = 4) with no grant → `in_ready = 0` after the 4th push. A 5th `in_valid` is not accepted. Grant 4 cycles → `bus_data` = 0x01, 0x02, 0x03, 0x04 on consecutive cycles, with FIFO order preserved across pointer wrap.
- Pair with the real arbiter and 4 clients, each holding 2 words → `GNT` rotates 0,1,2,3,0,1,2,3. Each client emits its 2 words with the correct `bus_id`.
- Sole client with 1 word: `gnt` is held high one extra cycle after the pop → `bus_valid = 0` that cycle and `idle_gnt_cnt = 1`. 300 such stale grants → `idle_gnt_cnt = 255`.
- Simultaneous `push` and `gnt` with `count = 0` → no pop, `bus_valid = 0`, `count = 1`, `req = 1`, `idle_gnt_cnt` increments.
- Assert `rst_n` low with 3 words queued and `gnt = 1` → `bus_valid`, `req`, `count` and `idle_gnt_cnt` go to 0 immediately. Nothing is emitted after reset release.
